demux_scan_sequencer: RTL and testbench
=======================================

Name: demux_scan_sequencer

Overview:
- Time-division sequencer that sits directly upstream of the 1x16 demultiplexer and drives its `in` and `sel` inputs.
- Captures a 16-bit parallel word on a start handshake, then steps `sel` through channels 0..15, holding each channel for DWELL clock cycles while presenting the matching data bit on `dout`.
- Signals completion with a one-cycle `done` pulse.
- Used on the Basys3 board to distribute switch or register values across 16 demux outputs (LEDs, enables) in a visible scan.

Parameters:
- DWELL, default 4: clock cycles spent on each channel; legal range 1..65535.
- CNT_W, default 16: width of the dwell counter; must satisfy 2^CNT_W > DWELL-1.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to begin a scan; sampled on rising clk
- data  input  16  word to distribute; bit n goes to channel n
- sel  output  4  channel select to demux; registered
- dout  output  1  data bit to demux `in`; registered
- valid  output  1  high while sel/dout carry a live channel
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse after channel 15 completes

Behaviour:
- Clocking and reset: one clock (`clk`). Reset `rst` is asynchronous and active-high. On `rst` all outputs are 0: sel=0, dout=0, valid=0, busy=0, done=0. State=IDLE, channel counter=0, dwell counter=0, shadow register=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SCAN, DONE.
- IDLE:
  - valid=0, busy=0, dout=0, sel=0.
  - If start=1 at an edge: latch data into the shadow register, set channel=0 and dwell=0, and go to SCAN.
- SCAN:
  - busy=1, valid=1, sel=channel, dout=shadow[channel].
  - Each cycle the dwell counter increments.
  - When dwell=DWELL-1 and channel<15: channel increments and dwell clears.
  - When dwell=DWELL-1 and channel=15: go to DONE.
- DONE:
  - One cycle: done=1, busy=0, valid=0, dout=0, sel=0.
  - Then go to IDLE unconditionally.
- Latency: with start sampled at edge k, SCAN occupies cycles k+1 .. k+16*DWELL and done is high in cycle k+16*DWELL+1. A new scan can begin 2 cycles after the last SCAN cycle at the earliest.
- start is ignored in SCAN and DONE; no queuing. Holding start high re-triggers from IDLE.
- data changes during SCAN have no effect; the shadow register is frozen until the next accepted start.
- DWELL=1: channel advances every cycle, 16 SCAN cycles total.
- Channel counter never wraps inside a scan; 15 is terminal.
- rst asserted mid-scan aborts immediately: outputs go to reset values, no done pulse. After rst deasserts the block is in IDLE.
- While valid=0, dout=0, so all downstream demux outputs are driven low.

Optional Feature:
- Macro: SCAN_AUTORESTART_EN.
- Defined: at the final SCAN cycle (channel=15, dwell=DWELL-1), if start=1:
  - re-latch data, set channel=0 and dwell=0, and stay in SCAN; the next cycle is channel 0 of the new word.
  - done pulses for one cycle concurrently with that first cycle; valid and busy stay high with no gap.
  - If start=0 at that edge, behaviour is as without the macro.
- Undefined: the DONE→IDLE sequence always applies; start at the final SCAN cycle is ignored.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, then release → sel=0, dout=0, valid=0, busy=0, done=0; nothing changes while start=0.
- Basic scan, DWELL=4: data=16'hA5C3, start pulsed 1 cycle → channels 0..15 each held 4 cycles with dout = bit n (bit0=1, bit1=1, bit2=0 …); done high exactly at cycle 65 after start; busy low afterward.
- Data stability: DWELL=2, data=16'hFFFF accepted, data switched to 16'h0000 at channel 3 → dout stays 1 for all 16 channels.
- Start while busy: second start pulse at channel 7 → ignored; single done pulse; total SCAN length 16*DWELL.
- Abort: rst asserted at channel 9 → outputs 0 within the same cycle (async); no done; a new start after release scans from channel 0.
- Back-to-back: start held high, DWELL=1 → macro off: 1-cycle DONE, 1-cycle IDLE gap, rescan; macro on: channel 15 followed directly by channel 0 with done=1 and no valid gap.

Source files
------------

// File: rtl/demux_scan_sequencer_if.sv
// Handshake and demux-drive bundle for demux_scan_sequencer.
// master: the block requesting scans (drives start/data).
// slave : the sequencer itself (drives sel/dout/valid/busy/done).
interface demux_scan_sequencer_if;
  logic        start;
  logic [15:0] data;
  logic [3:0]  sel;
  logic        dout;
  logic        valid;
  logic        busy;
  logic        done;

  modport master (
    output start, data,
    input  sel, dout, valid, busy, done
  );

  modport slave (
    input  start, data,
    output sel, dout, valid, busy, done
  );
endinterface

// File: rtl/demux_scan_sequencer.sv
// Time-division scan sequencer feeding a 1x16 demux. A 16-bit word is
// captured on start and its bits are presented on dout one channel at a
// time, each channel held for DWELL cycles, followed by a one-cycle done.
// Optional build macro: SCAN_AUTORESTART_EN -- a start seen on the final
// scan cycle re-latches data and restarts at channel 0 with no gap.
module demux_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  demux_scan_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [3:0]       CHAN_LAST  = 4'd15;

  state_t           state_p0;
  logic [3:0]       chan_p0;
  logic [CNT_W-1:0] dwell_p0;
  logic [15:0]      shadow_p0;
  logic [3:0]       sel_p0;
  logic             dout_p0;
  logic             valid_p0;
  logic             busy_p0;
  logic             done_p0;

  logic [3:0]       chan_nx;
  logic             dwell_end;

  // Next-channel index and end-of-dwell detect for the scan step.
  always_comb begin
    chan_nx   = chan_p0 + 4'd1;
    dwell_end = (dwell_p0 == DWELL_LAST);
  end

  // Scan FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p0  <= IDLE;
      chan_p0   <= '0;
      dwell_p0  <= '0;
      shadow_p0 <= '0;
      sel_p0    <= '0;
      dout_p0   <= 1'b0;
      valid_p0  <= 1'b0;
      busy_p0   <= 1'b0;
      done_p0   <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          done_p0 <= 1'b0;
          if (bus.start) begin
            shadow_p0 <= bus.data;
            chan_p0   <= '0;
            dwell_p0  <= '0;
            state_p0  <= SCAN;
            sel_p0    <= '0;
            dout_p0   <= bus.data[0];
            valid_p0  <= 1'b1;
            busy_p0   <= 1'b1;
          end else begin
            sel_p0   <= '0;
            dout_p0  <= 1'b0;
            valid_p0 <= 1'b0;
            busy_p0  <= 1'b0;
          end
        end

        SCAN: begin
          if (!dwell_end) begin
            dwell_p0 <= dwell_p0 + 1'b1;
            done_p0  <= 1'b0;
          end else if (chan_p0 != CHAN_LAST) begin
            chan_p0  <= chan_nx;
            dwell_p0 <= '0;
            sel_p0   <= chan_nx;
            dout_p0  <= shadow_p0[chan_nx];
            done_p0  <= 1'b0;
          end else begin
`ifdef SCAN_AUTORESTART_EN
            if (bus.start) begin
              // Seamless restart: done overlaps channel 0 of the new word.
              shadow_p0 <= bus.data;
              chan_p0   <= '0;
              dwell_p0  <= '0;
              sel_p0    <= '0;
              dout_p0   <= bus.data[0];
              done_p0   <= 1'b1;
            end else begin
              state_p0 <= DONE;
              sel_p0   <= '0;
              dout_p0  <= 1'b0;
              valid_p0 <= 1'b0;
              busy_p0  <= 1'b0;
              done_p0  <= 1'b1;
            end
`else
            state_p0 <= DONE;
            sel_p0   <= '0;
            dout_p0  <= 1'b0;
            valid_p0 <= 1'b0;
            busy_p0  <= 1'b0;
            done_p0  <= 1'b1;
`endif
          end
        end

        DONE: begin
          // start is ignored here; the block always passes through IDLE.
          state_p0 <= IDLE;
          chan_p0  <= '0;
          dwell_p0 <= '0;
          sel_p0   <= '0;
          dout_p0  <= 1'b0;
          valid_p0 <= 1'b0;
          busy_p0  <= 1'b0;
          done_p0  <= 1'b0;
        end

        default: begin
          state_p0 <= IDLE;
          sel_p0   <= '0;
          dout_p0  <= 1'b0;
          valid_p0 <= 1'b0;
          busy_p0  <= 1'b0;
          done_p0  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel   = sel_p0;
  assign bus.dout  = dout_p0;
  assign bus.valid = valid_p0;
  assign bus.busy  = busy_p0;
  assign bus.done  = done_p0;

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Directed bench for demux_scan_sequencer: three instances with DWELL of
// 4, 2 and 1 sharing one clock and reset.
module tb_demux_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  demux_scan_sequencer_if b4 ();
  demux_scan_sequencer_if b2 ();
  demux_scan_sequencer_if b1 ();

  demux_scan_sequencer #(.DWELL(4), .CNT_W(16)) u4 (.clk(clk), .rst(rst), .bus(b4));
  demux_scan_sequencer #(.DWELL(2), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .bus(b2));
  demux_scan_sequencer #(.DWELL(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // Observed status word: {valid, busy, done, sel[3:0], dout}
  logic [7:0] st4, st2, st1;
  assign st4 = {b4.valid, b4.busy, b4.done, b4.sel, b4.dout};
  assign st2 = {b2.valid, b2.busy, b2.done, b2.sel, b2.dout};
  assign st1 = {b1.valid, b1.busy, b1.done, b1.sel, b1.dout};

  localparam logic [7:0] ST_IDLE = 8'h00;
  localparam logic [7:0] ST_DONE = 8'h20;

  function automatic logic [7:0] scan_st(input int ch, input logic b);
    logic [3:0] c4;
    c4 = ch[3:0];
    return {1'b1, 1'b1, 1'b0, c4, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    b4.start = 0; b4.data = '0;
    b2.start = 0; b2.data = '0;
    b1.start = 0; b1.data = '0;
    rst = 1;
    repeat (3) tick();
    checks++;
    if (st4 !== ST_IDLE) begin failures++; $display("FAIL reset_u4 got=%h exp=%h", st4, ST_IDLE); end
    checks++;
    if (st1 !== ST_IDLE) begin failures++; $display("FAIL reset_u1 got=%h exp=%h", st1, ST_IDLE); end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (st4 !== ST_IDLE || st2 !== ST_IDLE) begin
        failures++;
        $display("FAIL idle_c%0d got=%h/%h exp=%h", i, st4, st2, ST_IDLE);
      end
    end
  endtask

  task automatic test_basic_scan;
    logic [15:0] d;
    d = 16'hA5C3;
    b4.data = d; b4.start = 1;
    tick();
    b4.start = 0;
    for (int c = 1; c <= 64; c++) begin
      checks++;
      if (st4 !== scan_st((c-1)/4, d[(c-1)/4])) begin
        failures++;
        $display("FAIL basic_c%0d got=%h exp=%h", c, st4, scan_st((c-1)/4, d[(c-1)/4]));
      end
      tick();
    end
    checks++;
    if (st4 !== ST_DONE) begin failures++; $display("FAIL basic_done got=%h exp=%h", st4, ST_DONE); end
    tick();
    checks++;
    if (st4 !== ST_IDLE) begin failures++; $display("FAIL basic_after got=%h exp=%h", st4, ST_IDLE); end
  endtask

  task automatic test_data_stable;
    b2.data = 16'hFFFF; b2.start = 1;
    tick();
    b2.start = 0;
    for (int c = 1; c <= 32; c++) begin
      if (c == 7) b2.data = 16'h0000;
      checks++;
      if (st2 !== scan_st((c-1)/2, 1'b1)) begin
        failures++;
        $display("FAIL stable_c%0d got=%h exp=%h", c, st2, scan_st((c-1)/2, 1'b1));
      end
      tick();
    end
    checks++;
    if (st2 !== ST_DONE) begin failures++; $display("FAIL stable_done got=%h exp=%h", st2, ST_DONE); end
    tick();
  endtask

  task automatic test_start_busy;
    int vcnt, dcnt, dcyc;
    vcnt = 0; dcnt = 0; dcyc = -1;
    b4.data = 16'h1234; b4.start = 1;
    tick();
    b4.start = 0;
    for (int c = 1; c <= 80; c++) begin
      b4.start = (c == 29);
      if (b4.valid) vcnt++;
      if (b4.done) begin dcnt++; dcyc = c; end
      tick();
    end
    b4.start = 0;
    checks++;
    if (vcnt != 64) begin failures++; $display("FAIL busy_len got=%0d exp=%0d", vcnt, 64); end
    checks++;
    if (dcnt != 1) begin failures++; $display("FAIL busy_dones got=%0d exp=%0d", dcnt, 1); end
    checks++;
    if (dcyc != 65) begin failures++; $display("FAIL busy_donecyc got=%0d exp=%0d", dcyc, 65); end
  endtask

  task automatic test_abort;
    logic [15:0] d;
    int dcnt;
    d = 16'h0F0F;
    dcnt = 0;
    b4.data = d; b4.start = 1;
    tick();
    b4.start = 0;
    repeat (36) tick();
    checks++;
    if (st4 !== scan_st(9, d[9])) begin failures++; $display("FAIL abort_ch9 got=%h exp=%h", st4, scan_st(9, d[9])); end
    rst = 1;
    #1;
    checks++;
    if (st4 !== ST_IDLE) begin failures++; $display("FAIL abort_async got=%h exp=%h", st4, ST_IDLE); end
    tick();
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (b4.done) dcnt++;
      checks++;
      if (st4 !== ST_IDLE) begin failures++; $display("FAIL abort_idle_c%0d got=%h exp=%h", i, st4, ST_IDLE); end
    end
    checks++;
    if (dcnt != 0) begin failures++; $display("FAIL abort_nodone got=%0d exp=%0d", dcnt, 0); end
    b4.data = 16'h0001; b4.start = 1;
    tick();
    b4.start = 0;
    checks++;
    if (st4 !== scan_st(0, 1'b1)) begin failures++; $display("FAIL abort_rescan0 got=%h exp=%h", st4, scan_st(0, 1'b1)); end
    repeat (4) tick();
    checks++;
    if (st4 !== scan_st(1, 1'b0)) begin failures++; $display("FAIL abort_rescan1 got=%h exp=%h", st4, scan_st(1, 1'b0)); end
    repeat (70) tick();
    checks++;
    if (st4 !== ST_IDLE) begin failures++; $display("FAIL abort_drain got=%h exp=%h", st4, ST_IDLE); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    d = 16'h8001;
    b1.data = d; b1.start = 1;
    tick();
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if (st1 !== scan_st(c-1, d[c-1])) begin
        failures++;
        $display("FAIL b2b_c%0d got=%h exp=%h", c, st1, scan_st(c-1, d[c-1]));
      end
      tick();
    end
`ifdef SCAN_AUTORESTART_EN
    checks++;
    if (st1 !== 8'hE1) begin failures++; $display("FAIL b2b_restart got=%h exp=%h", st1, 8'hE1); end
    tick();
    b1.start = 0;
    checks++;
    if (st1 !== scan_st(1, d[1])) begin failures++; $display("FAIL b2b_ch1 got=%h exp=%h", st1, scan_st(1, d[1])); end
    repeat (20) tick();
`else
    checks++;
    if (st1 !== ST_DONE) begin failures++; $display("FAIL b2b_done got=%h exp=%h", st1, ST_DONE); end
    tick();
    checks++;
    if (st1 !== ST_IDLE) begin failures++; $display("FAIL b2b_gap got=%h exp=%h", st1, ST_IDLE); end
    tick();
    b1.start = 0;
    checks++;
    if (st1 !== scan_st(0, d[0])) begin failures++; $display("FAIL b2b_rescan got=%h exp=%h", st1, scan_st(0, d[0])); end
    repeat (20) tick();
`endif
    checks++;
    if (st1 !== ST_IDLE) begin failures++; $display("FAIL b2b_drain got=%h exp=%h", st1, ST_IDLE); end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_data_stable();
    test_start_busy();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
